r2sdf_stage: RTL and testbench
==============================

# r2sdf_stage

Single radix-2 single-delay-feedback (R2SDF) stage controller for the pipelined FFT. It owns the depth-`depth` feedback delay line and the sample counter. It drives one combinational radix-2 butterfly, routing each sample to either the butterfly or the delay path. It emits a natural-order stream of sums followed by differences, tagging every difference with the twiddle index the downstream twiddle multiplier needs. Chaining log2(N) of these, with depth halving per stage, forms the FFT core.

## Interface
- `width`, 16: sample component width, signed two's complement.
- `depth`, 8: feedback delay length (butterfly span). Power of two, >= 2.
- `scale`, 0: arithmetic right shift applied to both butterfly outputs, 0..width-1.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input sample strobe.
- `in_ready` out 1: stage accepts input; low only in FLUSH.
- `in_re`, `in_im` in `width`: input sample.
- `flush` in 1: drain request, honoured only at a frame boundary.
- `out_valid` out 1: output sample strobe.
- `out_re`, `out_im` out `width`: output sample.
- `out_tw_en` out 1: output is a difference term and needs twiddle multiplication.
- `out_tw_idx` out clog2(`depth`): twiddle index k for W_(2·depth)^k. Valid with `out_tw_en`.

## Operation
- Definitions: `cnt` is clog2(2·`depth`) bits. `phase` is `cnt` MSB. `pos` is `cnt` low bits. `dl_out` is the oldest delay-line entry.
- An advance is one accepted input (`in_valid & in_ready`) or one FLUSH cycle. On each advance, the delay line shifts by one and `cnt` increments, wrapping 2·`depth`-1 to 0. There is no advance otherwise, so the stage is fully stallable.
- Butterfly: in0 = `dl_out`, in1 = input. sum = in0+in1 and diff = in0-in1, each truncated to `width` bits (wraps, no saturation), then arithmetic shift right by `scale`.
- RUN, phase 0: the input is written to the delay line. The output is `dl_out` with `out_tw_en`=1 and `out_tw_idx`=`pos`. This is the previous frame's difference. `out_valid` is asserted only if `primed`.
- RUN, phase 1: the output is the butterfly sum with `out_tw_en`=0. The butterfly diff is written to the delay line. `out_valid`=1. `primed` is set on the first phase-1 advance.
- FSM: RUN → FLUSH when `flush` & `cnt`==0 & `primed` & !`in_valid`.
  - `flush` with `in_valid` high in the same cycle: flush is ignored and the sample is accepted.
  - `flush` in any other condition: ignored.
- FLUSH: `in_ready`=0. The stage advances every cycle, writing zeros, and outputs `dl_out` with phase-0 tagging and `out_valid`=1. After `depth` advances (`cnt`==`depth`-1 → 0), it returns to RUN with `primed`=0.
- Reset values: state RUN, `cnt`=0, `primed`=0, delay line all zeros. All outputs are 0 except `in_ready`=1.

## Timing
- Outputs are registered. A sample accepted at edge t produces `out_*` valid after edge t+1, so `out_valid` pulses are one cycle after the accepting `in_valid`.
- Stage latency is `depth` samples. The first sum of a frame appears for input index `depth`. Differences of frame f appear during phase 0 of frame f+1, or during FLUSH.
- `in_ready` is decoded combinationally from the state register.
- FLUSH takes cycles t+1..t+`depth` when the flush is sampled at t. Its outputs are valid at t+2..t+`depth`+1. `in_ready` returns high at t+`depth`+1.
- `rst_n` low mid-frame or mid-FLUSH: everything is cleared immediately and asynchronously, and no `out_valid` is produced during reset. After release, the first `depth` accepted samples produce no `out_valid`.
- Back-to-back frames without flush give continuous `out_valid` once primed.

## Test plan
- Impulse, `depth`=4, `scale`=0: input 1,0,0,0,0,0,0,0, then flush. Outputs are sums 1,0,0,0 with `out_tw_en`=0, then diffs 1,0,0,0 with `out_tw_en`=1 and `out_tw_idx`=0,1,2,3.
- Constant (100,−50) ×8, `depth`=4, `scale`=1, then flush. Outputs are sums (100,−50) ×4, then diffs (0,0) ×4.
- Wrap, `width`=16, `depth`=2: in0=0x7FFF, in1=0x0001. `scale`=0 gives sum 0x8000. `scale`=1 gives sum 0xC000. Diff is 0x7FFE (`scale`=0) or 0x3FFF (`scale`=1).
- Stall: the same 3 frames streamed with random `in_valid` gaps. The output value and tag sequence is identical to the gap-free run, and exactly 3·2·`depth` `out_valid` pulses occur including the final flush.
- Flush rules: flush at `cnt`=3 is ignored. Flush with `in_valid` high is ignored and the sample is taken. A legal flush gives `in_ready` low for exactly `depth` cycles and `depth` diff outputs; the next `depth` inputs give no `out_valid`.
- Reset mid-frame: deassert `rst_n` after 5 samples. All outputs and `cnt` are zero immediately. A new impulse frame after release reproduces the first scenario exactly.

Source files
------------

// File: rtl/r2sdf_stage.sv
// Radix-2 single-delay-feedback FFT stage: feedback delay line, sample counter,
// butterfly routing and twiddle-index tagging of the difference terms.
module r2sdf_stage #(
    parameter int width = 16,
    parameter int depth = 8,
    parameter int scale = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [width-1:0]    in_re,
    input  logic signed [width-1:0]    in_im,
    input  logic                       flush,
    output logic                       out_valid,
    output logic signed [width-1:0]    out_re,
    output logic signed [width-1:0]    out_im,
    output logic                       out_tw_en,
    output logic [$clog2(depth)-1:0]   out_tw_idx
);

    localparam int cw = $clog2(2 * depth);
    localparam int pw = $clog2(depth);

    typedef enum logic {
        st_run,
        st_flush
    } state_t;

    state_t state, state_next;

    logic [cw-1:0]           cnt;
    logic                    primed;
    logic signed [width-1:0] dl_re [depth];
    logic signed [width-1:0] dl_im [depth];

    logic                    phase;
    logic [pw-1:0]           pos;
    logic                    advance;
    logic                    flush_last;
    logic signed [width-1:0] sum_re, sum_im, diff_re, diff_im;
    logic signed [width-1:0] bf_sum_re, bf_sum_im, bf_diff_re, bf_diff_im;
    logic signed [width-1:0] wr_re, wr_im;

    assign phase      = cnt[cw-1];
    assign pos        = cnt[pw-1:0];
    assign in_ready   = (state == st_run);
    assign advance    = (state == st_flush) || (in_valid && state == st_run);
    assign flush_last = (state == st_flush) && (cnt == cw'(depth - 1));

    // Sums/differences wrap at width bits before the arithmetic scaling shift.
    assign sum_re     = dl_re[depth-1] + in_re;
    assign sum_im     = dl_im[depth-1] + in_im;
    assign diff_re    = dl_re[depth-1] - in_re;
    assign diff_im    = dl_im[depth-1] - in_im;
    assign bf_sum_re  = sum_re >>> scale;
    assign bf_sum_im  = sum_im >>> scale;
    assign bf_diff_re = diff_re >>> scale;
    assign bf_diff_im = diff_im >>> scale;

    always_comb begin
        state_next = state;
        case (state)
            st_run: begin
                if (flush && cnt == '0 && primed && !in_valid)
                    state_next = st_flush;
            end
            st_flush: begin
                if (flush_last)
                    state_next = st_run;
            end
            default: state_next = st_run;
        endcase
    end

    always_comb begin
        wr_re = '0;
        wr_im = '0;
        if (state == st_run) begin
            wr_re = phase ? bf_diff_re : in_re;
            wr_im = phase ? bf_diff_im : in_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= st_run;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            primed     <= 1'b0;
            out_valid  <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
            out_tw_en  <= 1'b0;
            out_tw_idx <= '0;
            for (int unsigned i = 0; i < depth; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else if (advance) begin
            dl_re[0] <= wr_re;
            dl_im[0] <= wr_im;
            for (int unsigned i = 1; i < depth; i++) begin
                dl_re[i] <= dl_re[i-1];
                dl_im[i] <= dl_im[i-1];
            end
            cnt <= flush_last ? '0 : cnt + 1'b1;
            if (state == st_run && phase) begin
                primed     <= 1'b1;
                out_valid  <= 1'b1;
                out_re     <= bf_sum_re;
                out_im     <= bf_sum_im;
                out_tw_en  <= 1'b0;
                out_tw_idx <= '0;
            end else begin
                if (flush_last)
                    primed <= 1'b0;
                out_valid  <= (state == st_flush) || primed;
                out_re     <= dl_re[depth-1];
                out_im     <= dl_im[depth-1];
                out_tw_en  <= 1'b1;
                out_tw_idx <= pos;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed bench for r2sdf_stage: four instances (depth 4/2, scale 0/1) share
// clock, reset and input stimulus; each scenario checks the instance it targets.
module tb_r2sdf_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic flush;
    logic signed [15:0] in_re, in_im;

    logic rdy_a, ov_a, te_a;  logic signed [15:0] re_a, im_a;  logic [1:0] ti_a;
    logic rdy_b, ov_b, te_b;  logic signed [15:0] re_b, im_b;  logic [1:0] ti_b;
    logic rdy_c, ov_c, te_c;  logic signed [15:0] re_c, im_c;  logic [0:0] ti_c;
    logic rdy_d, ov_d, te_d;  logic signed [15:0] re_d, im_d;  logic [0:0] ti_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    r2sdf_stage #(.width(16), .depth(4), .scale(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(ov_a),
        .out_re(re_a), .out_im(im_a), .out_tw_en(te_a), .out_tw_idx(ti_a));
    r2sdf_stage #(.width(16), .depth(4), .scale(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(ov_b),
        .out_re(re_b), .out_im(im_b), .out_tw_en(te_b), .out_tw_idx(ti_b));
    r2sdf_stage #(.width(16), .depth(2), .scale(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(ov_c),
        .out_re(re_c), .out_im(im_c), .out_tw_en(te_c), .out_tw_idx(ti_c));
    r2sdf_stage #(.width(16), .depth(2), .scale(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d),
        .in_re(in_re), .in_im(in_im), .flush(flush), .out_valid(ov_d),
        .out_re(re_d), .out_im(im_d), .out_tw_en(te_d), .out_tw_idx(ti_d));

    task automatic cycle(input logic v, input logic signed [15:0] re,
                         input logic signed [15:0] im, input logic fl);
        in_valid = v;
        in_re    = re;
        in_im    = im;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_re    = '0;
        in_im    = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_re    = '0;
        in_im    = '0;
        rst_n    = 1'b0;
        #3;
        checks++;
        if ({ov_a, re_a, im_a, te_a, ti_a} !== '0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_a: got v=%0b re=%0d im=%0d en=%0b idx=%0d rdy=%0b, want all 0 rdy=1",
                     ov_a, re_a, im_a, te_a, ti_a, rdy_a);
        end
        checks++;
        if ({ov_b, ov_c, ov_d} !== 3'b000 || {rdy_b, rdy_c, rdy_d} !== 3'b111) begin
            errors++;
            $display("FAIL reset_others: got v=%b rdy=%b, want v=000 rdy=111",
                     {ov_b, ov_c, ov_d}, {rdy_b, rdy_c, rdy_d});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Impulse on the depth-4 scale-0 instance: sums 1,0,0,0 then diffs 1,0,0,0.
    task automatic test_impulse();
        logic signed [15:0] e;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i == 0) ? 16'sd1 : 16'sd0, 16'sd0, 1'b0);
            checks++;
            if (i < 4) begin
                if (ov_a !== 1'b0) begin
                    errors++;
                    $display("FAIL impulse_unprimed[%0d]: got v=%0b, want v=0", i, ov_a);
                end
            end else begin
                e = (i == 4) ? 16'sd1 : 16'sd0;
                if (ov_a !== 1'b1 || re_a !== e || im_a !== 16'sd0 || te_a !== 1'b0) begin
                    errors++;
                    $display("FAIL impulse_sum[%0d]: got v=%0b re=%0d im=%0d en=%0b, want v=1 re=%0d im=0 en=0",
                             i - 4, ov_a, re_a, im_a, te_a, e);
                end
            end
        end
        cycle(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++;
        if (ov_a !== 1'b0 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL impulse_flush_start: got v=%0b rdy=%0b, want v=0 rdy=0", ov_a, rdy_a);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 16'sd0, 16'sd0, 1'b0);
            e = (k == 0) ? 16'sd1 : 16'sd0;
            checks++;
            if (ov_a !== 1'b1 || re_a !== e || im_a !== 16'sd0 || te_a !== 1'b1 ||
                ti_a !== 2'(k) || rdy_a !== (k == 3)) begin
                errors++;
                $display("FAIL impulse_diff[%0d]: got v=%0b re=%0d im=%0d en=%0b idx=%0d rdy=%0b, want v=1 re=%0d im=0 en=1 idx=%0d rdy=%0b",
                         k, ov_a, re_a, im_a, te_a, ti_a, rdy_a, e, k, (k == 3));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, (i == 0) ? 16'sd1 : 16'sd0, 16'sd0, 1'b0);
        checks++;
        if (ov_a !== 1'b1 || re_a !== 16'sd1) begin
            errors++;
            $display("FAIL midreset_pre: got v=%0b re=%0d, want v=1 re=1", ov_a, re_a);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ov_a, re_a, im_a, te_a, ti_a} !== '0 || u_a.cnt !== '0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_clear: got v=%0b re=%0d en=%0b idx=%0d cnt=%0d rdy=%0b, want 0 0 0 0 0 rdy=1",
                     ov_a, re_a, te_a, ti_a, u_a.cnt, rdy_a);
        end
        #2;
        rst_n = 1'b1;
        test_impulse();
    endtask

    // Constant (100,-50) on the depth-4 scale-1 instance.
    task automatic test_constant();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'sd100, -16'sd50, 1'b0);
            checks++;
            if (i < 4) begin
                if (ov_b !== 1'b0) begin
                    errors++;
                    $display("FAIL const_unprimed[%0d]: got v=%0b, want v=0", i, ov_b);
                end
            end else if (ov_b !== 1'b1 || re_b !== 16'sd100 || im_b !== -16'sd50 || te_b !== 1'b0) begin
                errors++;
                $display("FAIL const_sum[%0d]: got v=%0b re=%0d im=%0d en=%0b, want v=1 re=100 im=-50 en=0",
                         i - 4, ov_b, re_b, im_b, te_b);
            end
        end
        cycle(1'b0, 16'sd0, 16'sd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 16'sd0, 16'sd0, 1'b0);
            checks++;
            if (ov_b !== 1'b1 || re_b !== 16'sd0 || im_b !== 16'sd0 || te_b !== 1'b1 || ti_b !== 2'(k)) begin
                errors++;
                $display("FAIL const_diff[%0d]: got v=%0b re=%0d im=%0d en=%0b idx=%0d, want v=1 re=0 im=0 en=1 idx=%0d",
                         k, ov_b, re_b, im_b, te_b, ti_b, k);
            end
        end
    endtask

    // Wrap-around on the depth-2 instances: in0=(7FFF,8000), in1=(0001,FFFF).
    task automatic test_wrap();
        do_reset();
        cycle(1'b1, 16'sh7FFF, 16'sh8000, 1'b0);
        cycle(1'b1, 16'sd0, 16'sd0, 1'b0);
        checks++;
        if (ov_c !== 1'b0 || ov_d !== 1'b0) begin
            errors++;
            $display("FAIL wrap_unprimed: got v=%0b/%0b, want 0/0", ov_c, ov_d);
        end
        cycle(1'b1, 16'sh0001, 16'shFFFF, 1'b0);
        checks++;
        if (ov_c !== 1'b1 || re_c !== 16'sh8000 || im_c !== 16'sh7FFF || te_c !== 1'b0) begin
            errors++;
            $display("FAIL wrap_sum_s0: got v=%0b re=%h im=%h en=%0b, want v=1 re=8000 im=7fff en=0",
                     ov_c, re_c, im_c, te_c);
        end
        checks++;
        if (ov_d !== 1'b1 || re_d !== 16'shC000 || im_d !== 16'sh3FFF || te_d !== 1'b0) begin
            errors++;
            $display("FAIL wrap_sum_s1: got v=%0b re=%h im=%h en=%0b, want v=1 re=c000 im=3fff en=0",
                     ov_d, re_d, im_d, te_d);
        end
        cycle(1'b1, 16'sd0, 16'sd0, 1'b0);
        cycle(1'b0, 16'sd0, 16'sd0, 1'b1);
        cycle(1'b0, 16'sd0, 16'sd0, 1'b0);
        checks++;
        if (ov_c !== 1'b1 || re_c !== 16'sh7FFE || im_c !== 16'sh8001 || te_c !== 1'b1 || ti_c !== 1'b0) begin
            errors++;
            $display("FAIL wrap_diff_s0: got v=%0b re=%h im=%h en=%0b idx=%0d, want v=1 re=7ffe im=8001 en=1 idx=0",
                     ov_c, re_c, im_c, te_c, ti_c);
        end
        checks++;
        if (ov_d !== 1'b1 || re_d !== 16'sh3FFF || im_d !== 16'shC000 || te_d !== 1'b1 || ti_d !== 1'b0) begin
            errors++;
            $display("FAIL wrap_diff_s1: got v=%0b re=%h im=%h en=%0b idx=%0d, want v=1 re=3fff im=c000 en=1 idx=0",
                     ov_d, re_d, im_d, te_d, ti_d);
        end
    endtask

    logic signed [15:0] exp_re [24];
    logic signed [15:0] exp_im [24];
    logic               exp_en [24];
    logic [1:0]         exp_idx [24];
    int                 sidx;

    function automatic logic signed [15:0] st_re(input int f, input int i);
        return 16'(f * 16 + i * 3 + 1);
    endfunction

    function automatic logic signed [15:0] st_im(input int f, input int i);
        return 16'(i * i - f * 2);
    endfunction

    task automatic stall_observe();
        if (ov_a === 1'b1) begin
            if (sidx < 24) begin
                checks++;
                if (re_a !== exp_re[sidx] || im_a !== exp_im[sidx] || te_a !== exp_en[sidx] ||
                    (exp_en[sidx] && ti_a !== exp_idx[sidx])) begin
                    errors++;
                    $display("FAIL stall_out[%0d]: got re=%0d im=%0d en=%0b idx=%0d, want re=%0d im=%0d en=%0b idx=%0d",
                             sidx, re_a, im_a, te_a, ti_a, exp_re[sidx], exp_im[sidx], exp_en[sidx], exp_idx[sidx]);
                end
            end
            sidx++;
        end
    endtask

    task automatic test_stall();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                exp_re[8*f+k]    = st_re(f, k) + st_re(f, k + 4);
                exp_im[8*f+k]    = st_im(f, k) + st_im(f, k + 4);
                exp_en[8*f+k]    = 1'b0;
                exp_idx[8*f+k]   = 2'(k);
                exp_re[8*f+4+k]  = st_re(f, k) - st_re(f, k + 4);
                exp_im[8*f+4+k]  = st_im(f, k) - st_im(f, k + 4);
                exp_en[8*f+4+k]  = 1'b1;
                exp_idx[8*f+4+k] = 2'(k);
            end
        end
        do_reset();
        sidx = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                while ($urandom_range(0, 2) == 0) begin
                    cycle(1'b0, 16'sd0, 16'sd0, 1'b0);
                    stall_observe();
                end
                cycle(1'b1, st_re(f, i), st_im(f, i), 1'b0);
                stall_observe();
            end
        end
        cycle(1'b0, 16'sd0, 16'sd0, 1'b1);
        stall_observe();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 16'sd0, 16'sd0, 1'b0);
            stall_observe();
        end
        checks++;
        if (sidx != 24) begin
            errors++;
            $display("FAIL stall_count: got %0d out_valid pulses, want 24", sidx);
        end
    endtask

    task automatic test_flush_rules();
        int low;
        int ndiff;
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 16'(i + 1), 16'sd0, 1'b0);
        cycle(1'b1, 16'sd0, 16'sd0, 1'b1);
        checks++;
        if (ov_a !== 1'b1 || re_a !== -16'sd4 || im_a !== 16'sd0 || te_a !== 1'b1 || ti_a !== 2'd0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL flush_with_valid: got v=%0b re=%0d im=%0d en=%0b idx=%0d rdy=%0b, want v=1 re=-4 im=0 en=1 idx=0 rdy=1",
                     ov_a, re_a, im_a, te_a, ti_a, rdy_a);
        end
        cycle(1'b1, 16'sd1, -16'sd1, 1'b0);
        cycle(1'b1, 16'sd4, -16'sd2, 1'b0);
        cycle(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++;
        if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL flush_cnt3: got v=%0b rdy=%0b, want v=0 rdy=1", ov_a, rdy_a);
        end
        for (int i = 3; i < 8; i++)
            cycle(1'b1, 16'(i * i), 16'(-i), 1'b0);
        cycle(1'b0, 16'sd0, 16'sd0, 1'b1);
        low   = (rdy_a === 1'b0) ? 1 : 0;
        ndiff = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 16'sd0, 16'sd0, 1'b0);
            if (rdy_a === 1'b0)
                low++;
            if (ov_a === 1'b1) begin
                checks++;
                if (re_a !== 16'(-8 * k - 16) || im_a !== 16'sd4 || te_a !== 1'b1 || ti_a !== 2'(k)) begin
                    errors++;
                    $display("FAIL flush_diff[%0d]: got re=%0d im=%0d en=%0b idx=%0d, want re=%0d im=4 en=1 idx=%0d",
                             k, re_a, im_a, te_a, ti_a, -8 * k - 16, k);
                end
                ndiff++;
            end
        end
        checks++;
        if (low != 4 || ndiff != 4) begin
            errors++;
            $display("FAIL flush_length: got ready-low=%0d diffs=%0d, want 4 and 4", low, ndiff);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'(i + 7), 16'sd0, 1'b0);
            checks++;
            if (ov_a !== 1'b0) begin
                errors++;
                $display("FAIL flush_unprimed[%0d]: got v=%0b, want v=0", i, ov_a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_constant();
        test_wrap();
        test_stall();
        test_flush_rules();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
